// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and the two-requester ALU arbiter.
//   - ALU opcode constants (alu "s" encoding) and the highest legal opcode
//   - response-slot state enum used by the arbiter FSM
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOTA = 4'd5;
    localparam logic [3:0] OP_NOTB = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;

    // Anything above this is rejected with rsp_err.
    localparam logic [3:0] OP_LAST = OP_INC;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two request channels, the response channel and the grant
// counters of alu_arbiter.
//   master : the requester/consumer side (drives requests and rsp_ready)
//   slave  : the arbiter side (drives readies, response and counters)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [7:0]       req0_a;
    logic [7:0]       req0_b;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [7:0]       req1_a;
    logic [7:0]       req1_b;
    logic [3:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [7:0]       rsp_out;
    logic             rsp_z;
    logic             rsp_n;
    logic             rsp_c;
    logic             rsp_v;
    logic             rsp_err;

    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err,
        output rsp_ready,
        input  gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err,
        input  rsp_ready,
        output gnt_cnt0, gnt_cnt1
    );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 8-bit ALU.
//   a, b : operands          op : opcode (alu_pkg OP_*)
//   y    : result            z/n/c/v : zero, negative, carry, overflow
// SUB reports a borrow in c. Shifts put the shifted-out bit in c.
// Opcodes above OP_LAST produce y=0 with c=v=0.
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] y,
    output logic       z,
    output logic       n,
    output logic       c,
    output logic       v
);

    logic [8:0] wide;

    // Compute result and carry/overflow per opcode; Z and N follow from y.
    always_comb begin
        wide = 9'd0;
        y    = 8'd0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                y    = wide[7:0];
                c    = wide[8];
                v    = (a[7] == b[7]) && (y[7] != a[7]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                y    = wide[7:0];
                c    = wide[8];
                v    = (a[7] != b[7]) && (y[7] != a[7]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            OP_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            OP_SHR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            OP_INC: begin
                wide = {1'b0, a} + 9'd1;
                y    = wide[7:0];
                c    = wide[8];
                v    = !a[7] && y[7];
            end
            default: y = 8'd0;
        endcase
        z = (y == 8'd0);
        n = y[7];
    end

endmodule

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker.
//   valid[1:0] : requesters asking this cycle
//   last       : id of the previously granted requester
//   en         : grants allowed this cycle
//   gnt[1:0]   : one-hot grant (or zero)
// On a tie the requester that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & valid[0] & (~valid[1] |  last);
    assign gnt[1] = en & valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one 8-bit ALU between two requesters with round-robin arbitration
// and holds one registered response (result, flags, id, illegal-op error).
//   clk, reset : clock and asynchronous active-high reset
//   bus        : alu_arbiter_if.slave (request channels 0/1, response
//                channel, per-requester saturating grant counters)
// Parameters: RR_INIT (reset value of last-grant pointer), CNT_W (counter width)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic RR_INIT = 1'b1,
    parameter int   CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_state_t      state;
    slot_state_t      state_nxt;
    logic             last;
    logic             slot_free;
    logic [1:0]       gnt;
    logic             grant;
    logic             win_id;

    logic [7:0]       sel_a;
    logic [7:0]       sel_b;
    logic [3:0]       sel_op;
    logic             op_err;
    logic [7:0]       alu_y;
    logic             alu_z;
    logic             alu_n;
    logic             alu_c;
    logic             alu_v;

    logic             rsp_id_q;
    logic [7:0]       rsp_out_q;
    logic             rsp_z_q;
    logic             rsp_n_q;
    logic             rsp_c_q;
    logic             rsp_v_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // The slot can take a new result when it is empty or being drained now.
    // Reset gates the picker so no ready is seen while reset is held.
    assign slot_free = (state == EMPTY) | bus.rsp_ready;

    rr_arb2 u_rr (
        .valid ({bus.req1_valid, bus.req0_valid}),
        .last  (last),
        .en    (slot_free & ~reset),
        .gnt   (gnt)
    );

    assign grant          = |gnt;
    assign win_id         = gnt[1];
    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    // Operand mux: whatever the winner presents in the grant cycle is used.
    assign sel_a  = win_id ? bus.req1_a  : bus.req0_a;
    assign sel_b  = win_id ? bus.req1_b  : bus.req0_b;
    assign sel_op = win_id ? bus.req1_op : bus.req0_op;
    assign op_err = (sel_op > OP_LAST);

    alu u_alu (
        .a  (sel_a),
        .b  (sel_b),
        .op (sel_op),
        .y  (alu_y),
        .z  (alu_z),
        .n  (alu_n),
        .c  (alu_c),
        .v  (alu_v)
    );

    // Slot state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A grant always (re)fills the slot; a drain with no refill empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (grant) state_nxt = FULL;
            FULL:    if (bus.rsp_ready) state_nxt = grant ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Response slot and round-robin pointer load on the grant edge only,
    // so the held response stays stable while the consumer stalls.
    // An illegal opcode still occupies the slot, with result and flags zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= RR_INIT;
            rsp_id_q  <= 1'b0;
            rsp_out_q <= 8'd0;
            rsp_z_q   <= 1'b0;
            rsp_n_q   <= 1'b0;
            rsp_c_q   <= 1'b0;
            rsp_v_q   <= 1'b0;
            rsp_err_q <= 1'b0;
        end else if (grant) begin
            last      <= win_id;
            rsp_id_q  <= win_id;
            rsp_out_q <= op_err ? 8'd0 : alu_y;
            rsp_z_q   <= op_err ? 1'b0 : alu_z;
            rsp_n_q   <= op_err ? 1'b0 : alu_n;
            rsp_c_q   <= op_err ? 1'b0 : alu_c;
            rsp_v_q   <= op_err ? 1'b0 : alu_v;
            rsp_err_q <= op_err;
        end
    end

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt[0] && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + CNT_ONE;
            if (gnt[1] && (cnt1_q != CNT_MAX)) cnt1_q <= cnt1_q + CNT_ONE;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_n     = rsp_n_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_v     = rsp_v_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.gnt_cnt0  = cnt0_q;
    assign bus.gnt_cnt1  = cnt1_q;

endmodule
